traffic_light_controller: RTL and testbench

- Highway/farm-road intersection controller. It is the consumer of the synchronized car-detect signal (C_sync) produced by the car sensor synchronizer.
- Moore FSM with four phases, plus an internal dwell counter driven by a tick enable (prescaled 1 Hz on board, tied high in simulation).
- Drives one-hot red/yellow/green lamps for both roads and exposes the phase code for the seven-segment/debug display.

---
 rtl/traffic_light_controller_pkg.sv | 16 +
 rtl/traffic_light_controller_dwell_timer.sv | 29 ++
 rtl/traffic_light_controller.sv | 85 ++++++++
 tb/tb_traffic_light_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_controller_pkg.sv
// Shared definitions for the highway/farm-road intersection controller:
// phase encodings and one-hot lamp patterns {red,yellow,green}.
package traffic_light_controller_pkg;

  typedef enum logic [1:0] {
    HG = 2'd0,
    HY = 2'd1,
    FG = 2'd2,
    FY = 2'd3
  } phase_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_light_controller_dwell_timer.sv
// Dwell counter: counts tick edges spent in the current phase, clears on a
// phase change and saturates at SAT so a long highway green never wraps.
module dwell_timer #(
  parameter int CNT_W = 8,
  parameter int SAT   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      if (clear) begin
        cnt <= '0;
      end else if (cnt != SAT_V) begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Four-phase Moore controller for a highway/farm-road intersection. State and
// dwell counter advance only on tick edges; lamps decode from the state alone.
module traffic_light_controller
  import traffic_light_controller_pkg::*;
#(
  parameter int LONG_CYCLES  = 10,
  parameter int SHORT_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car,
  output logic [2:0] hwy_light,
  output logic [2:0] farm_light,
  output logic [1:0] phase
);

  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_CYCLES - 1);

  phase_t           state;
  phase_t           state_next;
  phase_t           succ;
  logic             exit_phase;
  logic [CNT_W-1:0] cnt;

  dwell_timer #(
    .CNT_W (CNT_W),
    .SAT   (LONG_CYCLES - 1)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clear (exit_phase),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HG;
    end else begin
      state <= state_next;
    end
  end

  // exit_phase is a pure condition; the tick gating is applied both here and
  // inside the timer, so tick=0 edges freeze everything regardless of car.
  always_comb begin
    exit_phase = 1'b0;
    succ       = HG;
    hwy_light  = RED;
    farm_light = RED;
    case (state)
      HG: begin
        hwy_light  = GRN;
        exit_phase = car && (cnt == LONG_LAST);
        succ       = HY;
      end
      HY: begin
        hwy_light  = YEL;
        exit_phase = (cnt == SHORT_LAST);
        succ       = FG;
      end
      FG: begin
        farm_light = GRN;
        exit_phase = !car || (cnt == LONG_LAST);
        succ       = FY;
      end
      FY: begin
        farm_light = YEL;
        exit_phase = (cnt == SHORT_LAST);
        succ       = HG;
      end
      default: begin
        exit_phase = 1'b1;
        succ       = HG;
      end
    endcase
    state_next = (tick && exit_phase) ? succ : state;
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with a per-cycle lamp safety monitor.
module tb_traffic_light_controller;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic       car   = 1'b0;
  logic [2:0] hwy_light;
  logic [2:0] farm_light;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  traffic_light_controller #(
    .LONG_CYCLES  (10),
    .SHORT_CYCLES (3),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .car        (car),
    .hwy_light  (hwy_light),
    .farm_light (farm_light),
    .phase      (phase)
  );

  function automatic logic [2:0] exp_hwy(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_farm(input logic [1:0] p);
    case (p)
      2'd2:    return 3'b001;
      2'd3:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ((hwy_light !== 3'b100 && farm_light !== 3'b100) ||
          !$onehot(hwy_light) || !$onehot(farm_light)) begin
        n_fail++;
        $display("FAIL safety t=%0t hwy=%b farm=%b", $time, hwy_light, farm_light);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick  = 1'b1;
    car   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] exp_cnt;
    tick  = 1'b1;
    car   = 1'b0;
    reset = 1'b1;
    #1;
    mon_en = 1'b1;
    n_checks++;
    if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    n_checks++;
    if (hwy_light !== 3'b001) begin n_fail++; $display("FAIL reset_hwy got=%b exp=001", hwy_light); end
    n_checks++;
    if (farm_light !== 3'b100) begin n_fail++; $display("FAIL reset_farm got=%b exp=100", farm_light); end
    n_checks++;
    if (dut.u_timer.cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", dut.u_timer.cnt); end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step();
      exp_cnt = (e < 9) ? 8'(e) : 8'd9;
      n_checks++;
      if (phase !== 2'd0 || hwy_light !== 3'b001 || farm_light !== 3'b100) begin
        n_fail++;
        $display("FAIL hg_hold edge=%0d phase=%0d hwy=%b farm=%b exp phase=0 hwy=001 farm=100",
                 e, phase, hwy_light, farm_light);
      end
      n_checks++;
      if (dut.u_timer.cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL cnt_sat edge=%0d got=%0d exp=%0d", e, dut.u_timer.cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_car_held;
    logic [1:0] exp_p;
    apply_reset();
    car = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step();
      exp_p = (e < 10) ? 2'd0 : (e < 13) ? 2'd1 : (e < 23) ? 2'd2 : (e < 26) ? 2'd3 : 2'd0;
      n_checks++;
      if (phase !== exp_p) begin
        n_fail++;
        $display("FAIL car_held_phase edge=%0d got=%0d exp=%0d", e, phase, exp_p);
      end
      n_checks++;
      if (hwy_light !== exp_hwy(exp_p) || farm_light !== exp_farm(exp_p)) begin
        n_fail++;
        $display("FAIL car_held_lamps edge=%0d hwy=%b farm=%b exp hwy=%b farm=%b",
                 e, hwy_light, farm_light, exp_hwy(exp_p), exp_farm(exp_p));
      end
    end
  endtask

  task automatic test_farm_drop;
    logic [1:0] exp_p;
    apply_reset();
    car = 1'b1;
    repeat (16) step();
    n_checks++;
    if (phase !== 2'd2 || dut.u_timer.cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL farm_pre phase=%0d cnt=%0d exp phase=2 cnt=3", phase, dut.u_timer.cnt);
    end
    car = 1'b0;
    for (int e = 17; e <= 20; e++) begin
      step();
      exp_p = (e < 20) ? 2'd3 : 2'd0;
      n_checks++;
      if (phase !== exp_p || farm_light !== exp_farm(exp_p)) begin
        n_fail++;
        $display("FAIL farm_drop edge=%0d phase=%0d farm=%b exp phase=%0d farm=%b",
                 e, phase, farm_light, exp_p, exp_farm(exp_p));
      end
    end
  endtask

  task automatic test_slow_tick;
    logic [1:0] exp_p;
    logic [7:0] exp_cnt;
    apply_reset();
    tick = 1'b0;
    car  = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick = (e % 4 == 0);
      car  = tick ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      if (e < 40) begin
        exp_p = 2'd0; exp_cnt = 8'(e / 4);
      end else if (e < 52) begin
        exp_p = 2'd1; exp_cnt = 8'((e - 40) / 4);
      end else begin
        exp_p = 2'd2; exp_cnt = 8'((e - 52) / 4);
      end
      n_checks++;
      if (phase !== exp_p || dut.u_timer.cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL slow_tick edge=%0d phase=%0d cnt=%0d exp phase=%0d cnt=%0d",
                 e, phase, dut.u_timer.cnt, exp_p, exp_cnt);
      end
    end
    tick = 1'b1;
  endtask

  task automatic test_reset_mid;
    apply_reset();
    car = 1'b1;
    repeat (18) step();
    n_checks++;
    if (phase !== 2'd2 || dut.u_timer.cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL mid_pre phase=%0d cnt=%0d exp phase=2 cnt=5", phase, dut.u_timer.cnt);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (phase !== 2'd0 || hwy_light !== 3'b001 || farm_light !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_reset phase=%0d hwy=%b farm=%b exp phase=0 hwy=001 farm=100",
               phase, hwy_light, farm_light);
    end
    n_checks++;
    if (dut.u_timer.cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_cnt got=%0d exp=0", dut.u_timer.cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random;
    apply_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      tick = 1'($urandom_range(0, 1));
      car  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_car_held();
    test_farm_drop();
    test_slow_tick();
    test_reset_mid();
    test_random();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
